// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state encoding and default widths for the memory burst controller
// Ports: none (package).
package mem_ctrl_pkg;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int LW_DEF = 4;
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
endpackage

// File: rtl/mem_burst_ctrl_bus_driver.sv
// BusDriver: tristate driver for a shared bidirectional data bus
// Ports: en (drive enable), data (value to drive), bus (shared bus, Z when en=0).
module BusDriver
    import mem_ctrl_pkg::*;
#(
    parameter int W = DW_DEF
) (
    input  logic         en,
    input  logic [W-1:0] data,
    inout  wire  [W-1:0] bus
);
    assign bus = en ? data : {W{1'bz}};
endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: read/write burst sequencer owning a single-port Memory interface
// Ports: clock/reset_L (async active-low); req_* burst request handshake;
//        wr_* write-beat stream in; rd_* read-beat stream out (one-entry register);
//        done (pulse after last beat); busy (burst in progress);
//        mem_addr/mem_re/mem_we/mem_data Memory address, strobes and tristate bus.
module mem_burst_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    inout  wire  [DW-1:0] mem_data
);
    state_t        state, state_n;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] cnt_q;
    logic          start, wr_beat, rd_beat, last;

    assign last    = cnt_q == '0;
    assign start   = req_valid && req_ready;
    assign wr_beat = state == WRITE && wr_valid;
    // a read beat may refill the output register in the same cycle it is drained
    assign rd_beat = state == READ && (!rd_valid || rd_ready);

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = req_write ? WRITE : READ;
            WRITE:   if (wr_beat && last) state_n = IDLE;
            READ:    if (rd_beat && last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // req_ready is gated by reset_L so nothing is offered while reset is held
    always_comb begin
        busy      = state != IDLE;
        req_ready = reset_L && state == IDLE && !rd_valid;
        wr_ready  = state == WRITE;
        mem_we    = wr_beat;
        mem_re    = state == READ;
        mem_addr  = addr_q;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (start) begin
                addr_q <= req_addr;
                cnt_q  <= req_len;
            end else if (wr_beat || rd_beat) begin
                addr_q <= addr_q + AW'(1);
                cnt_q  <= cnt_q - LW'(1);
            end
            done     <= (wr_beat || rd_beat) && last;
            rd_valid <= rd_beat ? 1'b1 : (rd_ready ? 1'b0 : rd_valid);
            rd_data  <= rd_beat ? mem_data : rd_data;
        end
    end

    BusDriver #(.W(DW)) u_bus_driver (
        .en   (state == WRITE),
        .data (wr_data),
        .bus  (mem_data)
    );
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: randomized self-checking bench with a behavioural memory model
module tb_mem_burst_ctrl;
    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [3:0] req_len = 4'h0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_ready = 1'b0;
    logic       req_ready, wr_ready, rd_valid, done, busy, mem_re, mem_we;
    logic [7:0] rd_data, mem_addr;
    wire  [7:0] mem_data;

    logic [7:0] mem [256];
    logic       mem_init = 1'b0;
    logic [7:0] ref_mem [256];
    logic [7:0] beat_data [16];
    int vectors = 0, miscompares = 0;

    always #5 clock = ~clock;

    mem_burst_ctrl #(.AW(8), .DW(8), .LW(4)) dut (
        .clock(clock), .reset_L(reset_L),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .busy(busy),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_data(mem_data)
    );

    // single-port memory: combinational read onto the bus, synchronous write
    assign mem_data = mem_re ? mem[mem_addr] : 8'bz;
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
            mem_init <= 1'b1;
        end else if (mem_we) mem[mem_addr] <= mem_data;
    end

    always @(negedge clock) begin
        if (reset_L) begin
            vectors++;
            if ((wr_ready && mem_re) || (mem_we && mem_re) || (busy && req_ready) ||
                (mem_re && $isunknown(mem_data))) begin
                miscompares++;
                $display("FAIL bus_safety: wr_ready=%b mem_re=%b mem_we=%b busy=%b req_ready=%b mem_data=%h, required no overlap and known read data",
                         wr_ready, mem_re, mem_we, busy, req_ready, mem_data);
            end
        end
    end

    task automatic request(input logic wr, input logic [7:0] a, input logic [3:0] len);
        int n = 0;
        @(negedge clock);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = len;
        #1;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clock); #1; n++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_accept: req_ready=%b, required 1 within 50 cycles", req_ready);
        end
        @(negedge clock);
        req_valid = 1'b0; req_addr = 8'($urandom); req_len = 4'($urandom);
    endtask

    // mode: 0 streaming, 1 random stalls, 2 one beat then 3 idle cycles then beats
    task automatic do_write(input logic [7:0] a, input logic [3:0] len, input int mode, output int writes);
        logic [7:0] ea = a;
        int i = 0, n = 0;
        writes = 0;
        request(1'b1, a, len);
        while (i <= int'(len) && n < 400) begin
            wr_valid = (mode == 0) || (mode == 2 && (n == 0 || n == 4)) ||
                       (mode == 1 && $urandom_range(0, 2) != 0);
            wr_data = wr_valid ? beat_data[i] : 8'($urandom);
            #1;
            vectors++;
            if (mem_we !== wr_valid || wr_ready !== 1'b1 || busy !== 1'b1 || (wr_valid && mem_addr !== ea)) begin
                miscompares++;
                $display("FAIL write_beat: mem_we=%b wr_ready=%b busy=%b mem_addr=%h, required mem_we=%b wr_ready=1 busy=1 addr=%h",
                         mem_we, wr_ready, busy, mem_addr, wr_valid, ea);
            end
            if (mem_we === 1'b1) writes++;
            if (wr_valid) begin
                ref_mem[ea] = beat_data[i];
                ea++; i++;
            end
            @(negedge clock); n++;
        end
        wr_valid = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0 || mem_re !== 1'b0) begin
            miscompares++;
            $display("FAIL write_end: done=%b busy=%b wr_ready=%b mem_re=%b, required 1 0 0 0", done, busy, wr_ready, mem_re);
        end
        @(negedge clock); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL write_done_width: done=%b, required 0", done);
        end
    endtask

    // mode: 0 rd_ready held, 1 random, 2 pattern 1,0,0,1,1 then held
    task automatic do_read(input logic [7:0] a, input logic [3:0] len, input int mode);
        int got = 0, n = 0, dones = 0, issued;
        logic prev_busy = 1'b1, exp_busy;
        request(1'b0, a, len);
        while (got <= int'(len) && n < 400) begin
            rd_ready = (mode == 0) || (mode == 2 && n != 1 && n != 2) ||
                       (mode == 1 && $urandom_range(0, 1) == 1);
            #1;
            issued = got + int'(rd_valid);
            exp_busy = issued <= int'(len);
            vectors++;
            if (busy !== exp_busy || mem_re !== exp_busy || (exp_busy && mem_addr !== a + 8'(issued)) ||
                done !== (prev_busy && !exp_busy)) begin
                miscompares++;
                $display("FAIL read_state: busy=%b mem_re=%b mem_addr=%h done=%b, required busy=%b mem_re=%b addr=%h done=%b",
                         busy, mem_re, mem_addr, done, exp_busy, exp_busy, a + 8'(issued), prev_busy && !exp_busy);
            end
            if (done === 1'b1) dones++;
            prev_busy = exp_busy;
            if (rd_valid && rd_ready) begin
                vectors++;
                if (rd_data !== ref_mem[a + 8'(got)]) begin
                    miscompares++;
                    $display("FAIL read_data: beat %0d rd_data=%h, required %h", got, rd_data, ref_mem[a + 8'(got)]);
                end
                got++;
            end
            @(negedge clock); n++;
        end
        rd_ready = 1'b0;
        vectors++;
        if (dones != 1 || got != int'(len) + 1) begin
            miscompares++;
            $display("FAIL read_count: beats=%0d dones=%0d, required beats=%0d dones=1", got, dones, int'(len) + 1);
        end
    endtask

    task automatic test_reset;
        reset_L = 1'b0;
        #12;
        vectors++;
        if ({busy, rd_valid, done, mem_re, mem_we, req_ready, wr_ready} !== 7'b0 || rd_data !== 8'h00 || mem_addr !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b rd_valid=%b done=%b re=%b we=%b req_ready=%b wr_ready=%b rd_data=%h addr=%h, required all 0",
                     busy, rd_valid, done, mem_re, mem_we, req_ready, wr_ready, rd_data, mem_addr);
        end
        @(negedge clock); reset_L = 1'b1; #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_write_read;
        int w;
        beat_data[0] = 8'h11; beat_data[1] = 8'h22; beat_data[2] = 8'h33; beat_data[3] = 8'h44;
        do_write(8'h10, 4'd3, 0, w);
        vectors++;
        if (w != 4) begin
            miscompares++;
            $display("FAIL write_count: writes=%0d, required 4", w);
        end
        do_read(8'h10, 4'd3, 0);
    endtask

    task automatic test_backpressure;
        int w;
        beat_data[0] = 8'hA0; beat_data[1] = 8'hA1; beat_data[2] = 8'hA2;
        do_write(8'h20, 4'd2, 1, w);
        do_read(8'h20, 4'd2, 2);
    endtask

    task automatic test_write_stall;
        int w;
        beat_data[0] = 8'($urandom); beat_data[1] = 8'($urandom);
        do_write(8'h30, 4'd1, 2, w);
        vectors++;
        if (w != 2) begin
            miscompares++;
            $display("FAIL stall_writes: writes=%0d, required 2", w);
        end
        do_read(8'h30, 4'd1, 1);
    endtask

    task automatic test_wrap;
        int w, bad = 0;
        logic [7:0] keep = ref_mem[8'h02];
        for (int i = 0; i < 4; i++) beat_data[i] = 8'(i + 1);
        do_write(8'hFE, 4'd3, 0, w);
        do_read(8'hFE, 4'd3, 0);
        do_read(8'h02, 4'd0, 0);
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        vectors++;
        if (bad != 0 || mem[8'h02] !== keep || mem[8'h00] !== 8'h03 || mem[8'hFF] !== 8'h02) begin
            miscompares++;
            $display("FAIL wrap_memory: %0d locations differ, mem[02]=%h mem[00]=%h mem[FF]=%h, required 0 diffs, %h 03 02",
                     bad, mem[8'h02], mem[8'h00], mem[8'hFF], keep);
        end
    endtask

    task automatic test_back_to_back;
        int w;
        for (int i = 0; i < 3; i++) beat_data[i] = 8'($urandom);
        do_write(8'h50, 4'd2, 0, w);
        do_read(8'h50, 4'd2, 1);
        do_write(8'h51, 4'd0, 0, w);
        do_read(8'h50, 4'd2, 0);
    endtask

    task automatic test_reset_mid_read;
        int got = 0, n = 0;
        request(1'b0, 8'h40, 4'd3);
        rd_ready = 1'b1;
        while (got < 2 && n < 50) begin
            #1;
            if (rd_valid) got++;
            @(negedge clock); n++;
        end
        #2; reset_L = 1'b0; #1;
        vectors++;
        if (got != 2 || {mem_re, rd_valid, busy, done, req_ready} !== 5'b0 || rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_read: beats=%0d re=%b rd_valid=%b busy=%b done=%b req_ready=%b rd_data=%h, required 2 beats then all 0",
                     got, mem_re, rd_valid, busy, done, req_ready, rd_data);
        end
        @(negedge clock); reset_L = 1'b1; rd_ready = 1'b0;
        do_read(8'h80, 4'd3, 1);
    endtask

    task automatic test_random;
        int w;
        logic [7:0] a;
        logic [3:0] len;
        for (int k = 0; k < 24; k++) begin
            a = 8'($urandom);
            len = 4'($urandom);
            for (int i = 0; i < 16; i++) beat_data[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, len, $urandom_range(0, 1), w);
            else                           do_read(a, len, $urandom_range(0, 1));
        end
        do_read(8'h00, 4'hF, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        test_reset;
        test_write_read;
        test_backpressure;
        test_write_stall;
        test_wrap;
        test_back_to_back;
        test_reset_mid_read;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
Burst sequencer that sits directly upstream of the shared single-port Memory and owns its addr/re/we/tristate data bus. Client-side valid/ready requests open a read or write burst of 1..2**LW beats starting at a base address. Write beats are streamed in and written one per cycle; read beats are streamed out through a one-entry output register with backpressure.

Parameters:
AW, 8, address width; matches Memory AW
DW, 8, data width; matches Memory DW
LW, 4, burst-length field width; burst = req_len+1 beats, max 2**LW

Ports:
clock  input  1  system clock, all state on posedge
reset_L  input  1  reset, asynchronous, active-low
req_valid  input  1  burst request present
req_ready  output  1  controller accepts request this cycle
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  AW  burst base address
req_len  input  LW  beats minus one
wr_valid  input  1  write beat present
wr_ready  output  1  write beat consumed this cycle
wr_data  input  DW  write beat data
rd_valid  output  1  read beat available
rd_ready  input  1  consumer takes read beat
rd_data  output  DW  read beat data
done  output  1  one-cycle pulse after the last beat of a burst
busy  output  1  state != IDLE
mem_addr  output  AW  Memory address
mem_re  output  1  Memory read enable
mem_we  output  1  Memory write enable
mem_data  inout  DW  Memory data bus

Behaviour:
- Reset (async, reset_L low): state IDLE; addr_q, cnt_q, rd_data = 0; rd_valid, done, busy, mem_re, mem_we, req_ready, wr_ready = 0; mem_data released (Z) immediately, mid-burst included. Remaining beats of an interrupted burst are discarded.
- States: IDLE, WRITE, READ.
- IDLE:
  - req_ready = !rd_valid, so a new burst never starts while a read beat is still pending.
  - On req_valid && req_ready: addr_q <= req_addr, cnt_q <= req_len, go to WRITE if req_write, else READ.
  - mem_re = mem_we = 0; bus released.
- WRITE:
  - wr_ready = 1. mem_data driven with wr_data for the whole state; mem_re = 0; mem_we = wr_valid; mem_addr = addr_q.
  - A beat is a posedge with wr_valid: Memory captures it on that edge; addr_q <= addr_q+1 (mod 2**AW); cnt_q <= cnt_q-1.
  - If cnt_q == 0 on a beat: go to IDLE, done <= 1.
  - No wr_valid: stall, no write, state held.
- READ:
  - mem_re = 1; bus never driven by controller; mem_we = 0; mem_addr = addr_q.
  - Beat fires when !rd_valid || rd_ready: rd_data <= mem_data, rd_valid <= 1, addr_q++ (wrap), cnt_q--.
  - If cnt_q == 0 on a beat: go to IDLE, done <= 1.
  - rd_valid clears on rd_ready with no new beat, including in IDLE after the last beat.
  - Read latency: addr presented → rd_valid one cycle later. Full throughput with rd_ready held at 1.
- done: exactly one cycle, on the cycle after the final beat edge; otherwise 0.
- Bus safety: controller drive enable and mem_re are never 1 together. State changes pass through IDLE, which drives nothing, so every read↔write switch has at least one undriven cycle.
- Address wrap: base 8'hFE with len 3 accesses FE, FF, 00, 01.
- req_* inputs are ignored outside IDLE.
- cnt_q width is LW; len = 2**LW-1 yields 2**LW beats.

Decomposition:
- Package mem_ctrl_pkg: typedef enum logic [1:0] {IDLE, WRITE, READ} state_t, plus default width constants.
- One sub-module: the tristate drive of mem_data reuses the library BusDriver (en = state==WRITE, data = wr_data).
- Counter and address register stay inline.

Test Plan:
- Write burst: addr 8'h10, len 3, data 11,22,33,44 streamed back-to-back → mem_we for 4 cycles at 10..13; done pulses once; busy falls the same cycle. A read burst of the same range returns 11,22,33,44 in order.
- Read backpressure: preload 20..22 = A0,A1,A2; read len 2 with rd_ready toggled 1,0,0,1,1 → beats A0,A1,A2 in order, none dropped or duplicated; addr_q advances only on beats.
- Write stall: write len 1 with wr_valid low for 3 cycles between beats → exactly 2 writes; mem_we is 0 during the stall.
- Wrap: write len 3 at FE with 01..04 → locations FE, FF, 00, 01 hold 01..04; location 02 unchanged.
- Turnaround and contention: write then immediate read request → at least one cycle with mem_re = 0 and bus Z between bursts; no X on mem_data during any read cycle.
- Reset mid-read: assert reset_L = 0 after beat 2 of a 4-beat read → mem_re, rd_valid, busy drop asynchronously; the next request starts cleanly from its own base address.
